sparc_ifu_thrreq: RTL and testbench

SPARC_IFU_THRREQ -- requirements
Module: sparc_ifu_thrreq

---
 rtl/sparc_ifu_thrreq.sv | 100 ++++++++++
 tb/tb_sparc_ifu_thrreq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_thrreq.sv
// Per-thread 2-deep request queues feeding a shared output register
// through an external round-robin arbiter.
module sparc_ifu_thrreq (
    input  logic        clk,
    input  logic        reset,
    input  logic        se,
    input  logic        si,
    output logic        so,
    input  logic        enq_vld,
    input  logic [1:0]  enq_tid,
    input  logic [39:0] enq_data,
    output logic [3:0]  enq_full,
    output logic [3:0]  req_vec,
    input  logic [3:0]  grant_vec,
    output logic        advance,
    output logic        out_vld,
    output logic [1:0]  out_tid,
    output logic [39:0] out_data,
    input  logic        out_rdy,
    output logic        ovf_err
);

    logic [39:0]       mem [4][2];
    logic [3:0][1:0]   cnt;
    logic [3:0]        head;
    logic [3:0]        tail;
    logic              slot_free;
    logic [3:0]        gnt_m;
    logic [3:0]        eff;
    logic [1:0]        gtid;
    logic [3:0]        push;
    logic              drop;
    logic              scan_unused;

    assign scan_unused = se ^ si;
    assign so          = 1'b0;
    assign slot_free   = ~out_vld | out_rdy;

    always_comb begin
        req_vec  = '0;
        enq_full = '0;
        for (int t = 0; t < 4; t++) begin
            req_vec[t]  = (cnt[t] != 2'd0) & slot_free;
            enq_full[t] = (cnt[t] == 2'd2);
        end
    end

    // Isolate the lowest granted requester; stray grant bits fall away.
    assign gnt_m   = grant_vec & req_vec;
    assign eff     = gnt_m & (~gnt_m + 4'd1);
    assign advance = |eff;

    always_comb begin
        gtid = 2'd0;
        for (int t = 3; t >= 0; t--) begin
            if (eff[t]) gtid = 2'(t);
        end
    end

    // A full queue still accepts when its head leaves this cycle.
    always_comb begin
        push = '0;
        drop = 1'b0;
        if (enq_vld) begin
            if (cnt[enq_tid] != 2'd2 || eff[enq_tid]) push[enq_tid] = 1'b1;
            else drop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (|push) mem[enq_tid][tail[enq_tid]] <= enq_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            head     <= '0;
            tail     <= '0;
            out_vld  <= 1'b0;
            out_tid  <= 2'd0;
            out_data <= '0;
            ovf_err  <= 1'b0;
        end else begin
            for (int t = 0; t < 4; t++) begin
                cnt[t] <= cnt[t] + {1'b0, push[t]} - {1'b0, eff[t]};
                if (eff[t])  head[t] <= ~head[t];
                if (push[t]) tail[t] <= ~tail[t];
            end
            if (advance) begin
                out_vld  <= 1'b1;
                out_tid  <= gtid;
                out_data <= mem[gtid][head[gtid]];
            end else if (out_rdy) begin
                out_vld  <= 1'b0;
            end
            if (drop) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sparc_ifu_thrreq.sv
// Bench for sparc_ifu_thrreq: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_sparc_ifu_thrreq;

    logic        clk = 1'b0;
    logic        reset;
    logic        se = 1'b0;
    logic        si = 1'b0;
    logic        so;
    logic        enq_vld;
    logic [1:0]  enq_tid;
    logic [39:0] enq_data;
    logic [3:0]  enq_full;
    logic [3:0]  req_vec;
    logic [3:0]  grant_vec;
    logic        advance;
    logic        out_vld;
    logic [1:0]  out_tid;
    logic [39:0] out_data;
    logic        out_rdy;
    logic        ovf_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] mq [4][$];
    logic        m_vld;
    logic [1:0]  m_tid;
    logic [39:0] m_data;
    logic        m_ovf;
    logic [3:0]  e_req;
    logic        e_adv;
    int          e_g;

    sparc_ifu_thrreq dut (
        .clk(clk), .reset(reset), .se(se), .si(si), .so(so),
        .enq_vld(enq_vld), .enq_tid(enq_tid), .enq_data(enq_data),
        .enq_full(enq_full), .req_vec(req_vec), .grant_vec(grant_vec),
        .advance(advance), .out_vld(out_vld), .out_tid(out_tid),
        .out_data(out_data), .out_rdy(out_rdy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] full_vec();
        logic [3:0] f;
        f = '0;
        for (int k = 0; k < 4; k++) f[k] = (mq[k].size() == 2);
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mq[k].delete();
        m_vld  = 1'b0;
        m_tid  = 2'd0;
        m_data = '0;
        m_ovf  = 1'b0;
    endtask

    // Apply inputs and predict this cycle's request/grant outcome.
    task automatic drive(input logic v, input logic [1:0] t,
                         input logic [39:0] d, input logic [3:0] g,
                         input logic r);
        enq_vld   = v;
        enq_tid   = t;
        enq_data  = d;
        grant_vec = g;
        out_rdy   = r;
        e_req = '0;
        for (int k = 0; k < 4; k++)
            e_req[k] = (mq[k].size() != 0) && (!m_vld || r);
        e_g = -1;
        for (int k = 0; k < 4; k++)
            if (e_g < 0 && g[k] && e_req[k]) e_g = k;
        e_adv = (e_g >= 0);
        #1;
    endtask

    // Clock edge: pop the winner, then enqueue into whatever room remains.
    task automatic tick();
        @(posedge clk);
        if (e_adv) begin
            m_data = mq[e_g].pop_front();
            m_tid  = e_g[1:0];
            m_vld  = 1'b1;
        end else if (out_rdy) begin
            m_vld = 1'b0;
        end
        if (enq_vld) begin
            if (mq[enq_tid].size() < 2) mq[enq_tid].push_back(enq_data);
            else m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enq_vld = 0; enq_tid = 0; enq_data = 0; grant_vec = 0; out_rdy = 0;
        model_reset();
        #12;
        n_checks++;
        if ({req_vec, advance, enq_full, out_vld, ovf_err, so} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0",
                     {req_vec, advance, enq_full, out_vld, ovf_err, so});
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        drive(1, 2, 40'h12_3456_789A, 4'b0100, 1);
        n_checks++;
        if (req_vec !== 4'b0000 || advance !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pre req=%b adv=%b want 0000/0", req_vec, advance);
        end
        tick();
        drive(0, 0, 0, 4'b0100, 1);
        n_checks++;
        if (req_vec !== 4'b0100 || advance !== 1'b1) begin
            n_fail++;
            $display("FAIL single_req req=%b adv=%b want 0100/1", req_vec, advance);
        end
        tick();
        n_checks++;
        if (out_vld !== 1'b1 || out_tid !== 2'd2 || out_data !== 40'h12_3456_789A) begin
            n_fail++;
            $display("FAIL single_out vld=%b tid=%0d data=%h want 1/2/123456789a",
                     out_vld, out_tid, out_data);
        end
        drive(0, 0, 0, 4'b0100, 1);
        n_checks++;
        if (req_vec !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_after req=%b want 0000", req_vec);
        end
        tick();
    endtask

    task automatic test_overflow();
        drive(1, 1, 40'h1, 0, 1); tick();
        drive(1, 1, 40'h2, 0, 1); tick();
        n_checks++;
        if (enq_full !== 4'b0010 || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full full=%b ovf=%b want 0010/0", enq_full, ovf_err);
        end
        drive(1, 1, 40'h3, 0, 1); tick();
        n_checks++;
        if (ovf_err !== 1'b1 || enq_full !== 4'b0010) begin
            n_fail++;
            $display("FAIL ovf_set ovf=%b full=%b want 1/0010", ovf_err, enq_full);
        end
        for (int k = 1; k <= 2; k++) begin
            drive(0, 0, 0, 4'b0010, 1); tick();
            n_checks++;
            if (out_data !== 40'(k) || out_tid !== 2'd1) begin
                n_fail++;
                $display("FAIL ovf_drain%0d data=%h tid=%0d want %0d/1",
                         k, out_data, out_tid, k);
            end
        end
        drive(0, 0, 0, 4'b0010, 1);
        n_checks++;
        if (req_vec !== 4'b0000) begin
            n_fail++;
            $display("FAIL ovf_empty req=%b want 0000", req_vec);
        end
        tick();
    endtask

    task automatic test_all_threads();
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'(k), 40'hA0 + 40'(k), 4'b0000, 1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 4'b1111, 1);
            n_checks++;
            if (advance !== 1'b1 || req_vec !== 4'((4'b1111 << k))) begin
                n_fail++;
                $display("FAIL all_req%0d adv=%b req=%b", k, advance, req_vec);
            end
            tick();
            n_checks++;
            if (out_tid !== 2'(k) || out_data !== 40'hA0 + 40'(k)) begin
                n_fail++;
                $display("FAIL all_order%0d tid=%0d data=%h want %0d", k,
                         out_tid, out_data, k);
            end
        end
    endtask

    task automatic test_backpressure();
        drive(1, 3, 40'hBEEF, 4'b1000, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 4'b1000, 0);
            n_checks++;
            if (req_vec !== 4'b0000 || advance !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_req%0d req=%b adv=%b want 0000/0",
                         k, req_vec, advance);
            end
            tick();
            n_checks++;
            if (out_vld !== 1'b1 || out_tid !== 2'd3 || out_data !== 40'hA3) begin
                n_fail++;
                $display("FAIL bp_hold%0d vld=%b tid=%0d data=%h want 1/3/a3",
                         k, out_vld, out_tid, out_data);
            end
        end
        drive(0, 0, 0, 4'b1000, 1);
        n_checks++;
        if (req_vec !== 4'b1000 || advance !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release req=%b adv=%b want 1000/1", req_vec, advance);
        end
        tick();
        n_checks++;
        if (out_data !== 40'hBEEF) begin
            n_fail++;
            $display("FAIL bp_data got=%h want beef", out_data);
        end
        drive(0, 0, 0, 0, 1); tick();
    endtask

    task automatic test_idle_grant();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 4'b0001, 1);
            n_checks++;
            if (advance !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_adv%0d got=%b want 0", k, advance);
            end
            tick();
            n_checks++;
            if (out_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_vld%0d got=%b want 0", k, out_vld);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 40'hAA, 0, 1); tick();
        drive(1, 0, 40'hBB, 0, 1); tick();
        drive(1, 0, 40'hCC, 4'b0001, 1); tick();
        n_checks++;
        if (out_vld !== 1'b1 || out_data !== 40'hAA || enq_full !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_setup vld=%b data=%h full=%b want 1/aa/0001",
                     out_vld, out_data, enq_full);
        end
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({req_vec, advance, enq_full, out_vld, out_tid, ovf_err, so} !== 14'd0
            || out_data !== 40'd0) begin
            n_fail++;
            $display("FAIL mid_reset got=%h data=%h want 0",
                     {req_vec, advance, enq_full, out_vld, out_tid, ovf_err, so},
                     out_data);
        end
        #2;
        reset = 1'b0;
        drive(1, 1, 40'hDD, 0, 1); tick();
        drive(0, 0, 0, 4'b1111, 1);
        n_checks++;
        if (req_vec !== 4'b0010 || advance !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_req req=%b adv=%b want 0010/1", req_vec, advance);
        end
        tick();
        n_checks++;
        if (out_tid !== 2'd1 || out_data !== 40'hDD) begin
            n_fail++;
            $display("FAIL mid_first tid=%0d data=%h want 1/dd", out_tid, out_data);
        end
        drive(0, 0, 0, 0, 1); tick();
    endtask

    task automatic test_random();
        logic [39:0] d;
        for (int i = 0; i < 400; i++) begin
            d = {8'($urandom()), 32'($urandom())};
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d,
                  4'($urandom()), ($urandom_range(0, 3) != 0));
            n_checks++;
            if (req_vec !== e_req || advance !== e_adv) begin
                n_fail++;
                $display("FAIL rnd_req%0d req=%b adv=%b want %b/%b",
                         i, req_vec, advance, e_req, e_adv);
            end
            tick();
            n_checks++;
            if (out_vld !== m_vld || enq_full !== full_vec() || ovf_err !== m_ovf
                || (m_vld && (out_tid !== m_tid || out_data !== m_data))) begin
                n_fail++;
                $display("FAIL rnd_state%0d vld=%b tid=%0d data=%h full=%b ovf=%b want %b/%0d/%h/%b/%b",
                         i, out_vld, out_tid, out_data, enq_full, ovf_err,
                         m_vld, m_tid, m_data, full_vec(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_all_threads();
        test_backpressure();
        test_idle_grant();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
